upsample_row_stream: RTL and testbench

UPSAMPLE_ROW_STREAM -- requirements
Module: upsample_row_stream

---
 rtl/upsample_row_stream.sv | 160 ++++++++++++++++
 tb/tb_upsample_row_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_row_stream.sv
// upsample_row_stream
// 2x row upsampler. For every row of ROW_LEN input pixels it emits 2*ROW_LEN
// output pixels. The first and last outputs are exact copies of the first and
// last input pixels. Between each neighbouring pair (a,b) it inserts
//   P = (a>>1)+(a>>2)+(b>>2)  and  Q = (b>>2)+(b>>1)+(a>>2),
// with each shift truncating and each sum wrapping modulo 2^length.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input pixel
//   in_valid   in_data is valid
//   in_ready   block can accept a pixel this cycle
//   out_data   upsampled pixel (registered)
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   out_last   marks the final output of a row (registered)

module upsample_row_stream #(
  parameter int length  = 16,
  parameter int ROW_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [length-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;

  typedef enum logic [2:0] {
    S_FIRST,
    S_EDGE_L,
    S_NEXT,
    S_P,
    S_Q,
    S_EDGE_R
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [length-1:0] prev, prev_nxt;
  logic [length-1:0] q_hold, q_hold_nxt;
  logic [length-1:0] data_r, data_nxt;
  logic              last_r, last_nxt;
  logic              ready_c;
  logic              valid_c;
  logic [CW-1:0]     cnt_inc;

  function automatic logic [length-1:0] calc_p(input logic [length-1:0] a,
                                               input logic [length-1:0] b);
    calc_p = (a >> 1) + (a >> 2) + (b >> 2);
  endfunction

  function automatic logic [length-1:0] calc_q(input logic [length-1:0] a,
                                               input logic [length-1:0] b);
    calc_q = (b >> 2) + (b >> 1) + (a >> 2);
  endfunction

  // Accepted-pixel counter wraps to zero on the last pixel of a row, so a
  // zero count after the Q output means the row's pixels are exhausted.
  assign cnt_inc = (cnt == CW'(ROW_LEN - 1)) ? '0 : cnt + 1'b1;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FIRST;
      cnt    <= '0;
      prev   <= '0;
      q_hold <= '0;
      data_r <= '0;
      last_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      prev   <= prev_nxt;
      q_hold <= q_hold_nxt;
      data_r <= data_nxt;
      last_r <= last_nxt;
    end
  end

  // Next-state and next-data logic. P and Q are both computed when the new
  // pixel arrives; Q is parked in q_hold so that prev can immediately take
  // the new pixel, ready for the following pair or the right edge copy.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    prev_nxt   = prev;
    q_hold_nxt = q_hold;
    data_nxt   = data_r;
    last_nxt   = last_r;
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    case (state)
      S_FIRST: begin
        ready_c = 1'b1;
        if (in_valid) begin
          data_nxt  = in_data;
          prev_nxt  = in_data;
          cnt_nxt   = cnt_inc;
          state_nxt = S_EDGE_L;
        end
      end
      S_EDGE_L: begin
        valid_c = 1'b1;
        if (out_ready) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        ready_c = 1'b1;
        if (in_valid) begin
          data_nxt   = calc_p(prev, in_data);
          q_hold_nxt = calc_q(prev, in_data);
          prev_nxt   = in_data;
          cnt_nxt    = cnt_inc;
          state_nxt  = S_P;
        end
      end
      S_P: begin
        valid_c = 1'b1;
        if (out_ready) begin
          data_nxt  = q_hold;
          state_nxt = S_Q;
        end
      end
      S_Q: begin
        valid_c = 1'b1;
        if (out_ready) begin
          if (cnt == '0) begin
            data_nxt  = prev;
            last_nxt  = 1'b1;
            state_nxt = S_EDGE_R;
          end else begin
            state_nxt = S_NEXT;
          end
        end
      end
      S_EDGE_R: begin
        valid_c = 1'b1;
        if (out_ready) begin
          last_nxt  = 1'b0;
          state_nxt = S_FIRST;
        end
      end
      default: state_nxt = S_FIRST;
    endcase
  end

  // in_ready is masked by rst so nothing is offered during the reset cycle.
  assign in_ready  = ready_c & ~rst;
  assign out_valid = valid_c;
  assign out_data  = data_r;
  assign out_last  = last_r;

endmodule

// File: tb/tb_upsample_row_stream.sv
module tb_upsample_row_stream;

  localparam int LEN = 16;
  localparam int N   = 4;

  typedef struct packed {
    logic [LEN-1:0] d;
    logic           l;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [LEN-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  exp_t           exp_q[$];
  logic [LEN-1:0] cap[$];
  int             checks = 0;
  int             errors = 0;
  int             outs   = 0;
  int             lasts  = 0;
  int             idx    = 0;
  logic [LEN-1:0] mprev  = '0;

  upsample_row_stream #(.length(LEN), .ROW_LEN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LEN-1:0] mp(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int s;
    s = int'(a) / 2 + int'(a) / 4 + int'(b) / 4;
    mp = LEN'(s);
  endfunction

  function automatic logic [LEN-1:0] mq(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int s;
    s = int'(b) / 4 + int'(b) / 2 + int'(a) / 4;
    mq = LEN'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one pixel (called at posedge+1); returns at posedge+1 after transfer.
  task automatic send(input logic [LEN-1:0] d);
    int guard;
    guard    = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (idx == 0) begin
        exp_q.push_back('{d: d, l: 1'b0});
      end else begin
        exp_q.push_back('{d: mp(mprev, d), l: 1'b0});
        exp_q.push_back('{d: mq(mprev, d), l: 1'b0});
        if (idx == N - 1) exp_q.push_back('{d: d, l: 1'b1});
      end
      mprev = d;
      idx   = (idx + 1) % N;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare every output transfer against the queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_output: observed %h expected none", out_data);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_last", 32'(out_last), 32'(e.l));
      end
      cap.push_back(out_data);
      outs++;
      if (out_last) lasts++;
    end
  end

  initial begin
    logic [LEN-1:0] golden [0:7];
    int outs0;
    int lasts0;
    golden[0] = 16'h0100; golden[1] = 16'h0140; golden[2] = 16'h01C0; golden[3] = 16'h0240;
    golden[4] = 16'h02C0; golden[5] = 16'h0340; golden[6] = 16'h03C0; golden[7] = 16'h0400;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic row against literal golden values.
    cap.delete();
    send(16'h0100); send(16'h0200); send(16'h0300); send(16'h0400);
    drain();
    check("golden_count", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap.size()) check($sformatf("golden_%0d", i), 32'(cap[i]), 32'(golden[i]));
    end

    // Truncation row, with an input stall while awaiting x1.
    send(16'h0003);
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_in_ready", 32'(in_ready), 32'd1);
      check("stall_out_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0001); send(16'h0002); send(16'h0006);
    drain();

    // Wrap-around row.
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
    drain();

    // Backpressure while presenting P; garbage offered on the input.
    send(16'h1000); send(16'h2000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h1400);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(16'h3000); send(16'h4000);
    drain();

    // Reset mid-row while o1 is presented.
    send(16'h0050); send(16'h0060);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    exp_q.delete();
    idx   = 0;
    mprev = '0;
    rst   = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
    drain();

    // Two rows back to back.
    outs0  = outs;
    lasts0 = lasts;
    send(16'h0A00); send(16'h0B00); send(16'h0C00); send(16'h0D00);
    send(16'h7000); send(16'h0100); send(16'h8001); send(16'h1234);
    drain();
    check("b2b_outputs", 32'(outs - outs0), 32'd16);
    check("b2b_lasts", 32'(lasts - lasts0), 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
